// File: rtl/load_store_unit_pkg.sv
// Shared RV32I types for the memory stage: funct3 encodings,
// LSU state and access-size helpers.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  // Unknown encodings fall through to a word access.
  function automatic lsu_size_t lsu_size(
    input logic       load,
    input logic [2:0] f3
  );
    lsu_size_t s;
    s = SZ_W;
    if (load) begin
      case (load_funct3_t'(f3))
        LB, LBU: s = SZ_B;
        LH, LHU: s = SZ_H;
        default: s = SZ_W;
      endcase
    end else begin
      case (store_funct3_t'(f3))
        SB:      s = SZ_B;
        SH:      s = SZ_H;
        default: s = SZ_W;
      endcase
    end
    return s;
  endfunction

  function automatic logic lsu_aligned(
    input lsu_size_t  s,
    input logic [1:0] off
  );
    logic ok;
    case (s)
      SZ_H:    ok = ~off[0];
      SZ_W:    ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the LSU
// (master) and the memory (slave).
interface load_store_unit_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;

  modport master (
    output address, read, write, wmask, wdata,
    input  rdata, resp
  );

  modport slave (
    input  address, read, write, wmask, wdata,
    output rdata, resp
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Extracts the addressed byte/half/word from a memory word
// and sign- or zero-extends it.
module lsu_load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{offset, 3'b000} +: 8];
  assign h = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    unique case (load_funct3_t'(funct3))
      LB:      result = {{24{b[7]}}, b};
      LH:      result = {{16{h[15]}}, h};
      LBU:     result = {24'b0, b};
      LHU:     result = {16'b0, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one dmem request per load/store,
// pipeline stall until the response, formatted load data out.
module load_store_unit
  import rv32i_types::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_load,
  input  logic                      in_store,
  input  logic [2:0]                in_funct3,
  input  logic [31:0]               in_addr,
  input  logic [31:0]               in_wdata,
  input  logic                      flush,
  load_store_unit_if.master         dmem,
  output logic                      stall_o,
  output logic                      ld_valid_o,
  output logic [31:0]               ld_data_o,
  output logic                      misaligned_o,
  output logic                      timeout_o
);

  localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);

  lsu_state_t  state;
  lsu_state_t  state_n;
  lsu_size_t   size;

  logic        mem_op;
  logic        aligned;
  logic        idle;
  logic        accept;

  logic [3:0]  mask_n;
  logic [31:0] wdata_n;

  logic [31:0] addr_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;
  logic        read_q;
  logic        write_q;
  logic        load_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        flushed_q;
  logic [31:0] ld_data_q;
  logic        to_q;

  logic [31:0] cnt;
  logic [31:0] cnt_n;
  logic        hit_to;
  logic [31:0] align_out;

  assign mem_op  = in_valid & (in_load | in_store);
  assign size    = lsu_size(in_load, in_funct3);
  assign aligned = lsu_aligned(size, in_addr[1:0]);
  assign idle    = (state == IDLE);
  assign accept  = idle & mem_op & aligned & ~flush;

  assign misaligned_o = idle & mem_op & ~aligned & ~flush;

  always_comb begin
    mask_n  = 4'b1111;
    wdata_n = in_wdata;
    unique case (1'b1)
      size == SZ_B: begin
        mask_n  = 4'b0001 << in_addr[1:0];
        wdata_n = {4{in_wdata[7:0]}};
      end
      size == SZ_H: begin
        mask_n  = 4'b0011 << in_addr[1:0];
        wdata_n = {2{in_wdata[15:0]}};
      end
      default: begin
        mask_n  = 4'b1111;
        wdata_n = in_wdata;
      end
    endcase
    if (in_load || !in_store) begin
      mask_n = 4'b0000;
    end
  end

  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = BUSY;
          stall_o = 1'b1;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (dmem.resp) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Counter saturates so a hung bus never wraps back under the limit.
  assign cnt_n  = (cnt == '1) ? cnt : cnt + 32'd1;
  assign hit_to = (TO != '0) && (cnt_n >= TO) && !dmem.resp;

  lsu_load_align u_align (
    .rdata  (dmem.rdata),
    .funct3 (f3_q),
    .offset (off_q),
    .result (align_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      mask_q    <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      load_q    <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      flushed_q <= 1'b0;
      ld_data_q <= '0;
      to_q      <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q    <= {in_addr[31:2], 2'b00};
        mask_q    <= mask_n;
        wdata_q   <= wdata_n;
        read_q    <= in_load;
        write_q   <= in_store & ~in_load;
        load_q    <= in_load;
        f3_q      <= in_funct3;
        off_q     <= in_addr[1:0];
        flushed_q <= 1'b0;
        cnt       <= '0;
      end
      if (state == BUSY) begin
        cnt <= cnt_n;
        if (flush) begin
          flushed_q <= 1'b1;
        end
        if (hit_to) begin
          to_q <= 1'b1;
        end
        if (dmem.resp) begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          if (load_q) begin
            ld_data_q <= align_out;
          end
        end
      end
    end
  end

  assign dmem.address = addr_q;
  assign dmem.read    = read_q;
  assign dmem.write   = write_q;
  assign dmem.wmask   = mask_q;
  assign dmem.wdata   = wdata_q;

  assign ld_valid_o = (state == DONE) & load_q & ~flushed_q;
  assign ld_data_o  = ld_data_q;
  assign timeout_o  = to_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level
// model checked every cycle plus literal spot checks.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_load;
  logic        in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        flush;
  logic        stall_o;
  logic        ld_valid_o;
  logic [31:0] ld_data_o;
  logic        misaligned_o;
  logic        timeout_o;

  load_store_unit_if dmem ();

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_load      (in_load),
    .in_store     (in_store),
    .in_funct3    (in_funct3),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .flush        (flush),
    .dmem         (dmem),
    .stall_o      (stall_o),
    .ld_valid_o   (ld_valid_o),
    .ld_data_o    (ld_data_o),
    .misaligned_o (misaligned_o),
    .timeout_o    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  int n_stall = 0;
  int n_read  = 0;

  logic        e_stall, e_read, e_write, e_ldv, e_mis, e_to;
  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_mask;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int size_of(input bit ld, input logic [2:0] f3);
    if (ld) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
    end
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3,
      input logic [31:0] rd, input int off);
    int sz;
    longint v;
    sz = size_of(1'b1, f3);
    if (sz == 4) return rd;
    v = (longint'(rd) >> (8 * off)) % (64'sd1 << (8 * sz));
    if (f3 < 3'd4 && v >= (64'sd1 << (8 * sz - 1)))
      v = v - (64'sd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_mask(input int sz, input int off);
    int m;
    m = ((1 << sz) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input int sz,
                                            input logic [31:0] wd);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chkb("stall", stall_o, e_stall);
      chkb("dmem_read", dmem.read, e_read);
      chkb("dmem_write", dmem.write, e_write);
      chkb("ld_valid", ld_valid_o, e_ldv);
      chkb("misaligned", misaligned_o, e_mis);
      chkb("timeout", timeout_o, e_to);
      if (e_read || e_write) begin
        chk("dmem_address", dmem.address, e_addr);
        chk("dmem_wmask", {28'b0, dmem.wmask}, {28'b0, e_mask});
      end
      if (e_write) chk("dmem_wdata", dmem.wdata, e_wdata);
      if (e_ldv) chk("ld_data", ld_data_o, e_ld);
      n_stall += int'(stall_o);
      n_read  += int'(dmem.read);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; in_load = 0; in_store = 0; flush = 0;
    dmem.resp = 0;
    e_stall = 0; e_read = 0; e_write = 0; e_ldv = 0; e_mis = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      quiet();
      tick();
    end
  endtask

  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] wd,
      input logic [31:0] rd, input int delay, input int flush_at,
      input bit lit_en, input logic [31:0] l_addr,
      input logic [3:0] l_mask, input logic [31:0] l_wdata,
      input logic [31:0] l_ld);
    int sz;
    int off;
    bit flushed;
    sz = size_of(ld, f3);
    off = int'(addr[1:0]);
    flushed = 0;
    in_valid = 1; in_load = ld; in_store = st; in_funct3 = f3;
    in_addr = addr; in_wdata = wd; flush = 0;
    e_read = 0; e_write = 0; e_ldv = 0;
    if (off % sz != 0) begin
      e_mis = 1; e_stall = 0;
      tick();
      quiet();
      return;
    end
    e_mis = 0; e_stall = 1;
    e_addr = addr & 32'hFFFF_FFFC;
    e_mask = st ? exp_mask(sz, off) : 4'b0000;
    e_wdata = exp_wdata(sz, wd);
    tick();
    for (int i = 1; i <= delay; i++) begin
      e_to = e_to | (i - 1 >= T);
      e_read = ld; e_write = st; e_stall = 1;
      dmem.resp = (i == delay);
      dmem.rdata = (i == delay) ? rd : (32'h0BAD_0BAD ^ i);
      flush = (i == flush_at);
      if (i == flush_at) flushed = 1;
      if (lit_en && i == 1) begin
        #3;
        chk("lit_addr", dmem.address, l_addr);
        chk("lit_mask", {28'b0, dmem.wmask}, {28'b0, l_mask});
        if (st) chk("lit_wdata", dmem.wdata, l_wdata);
      end
      tick();
    end
    dmem.resp = 0; flush = 0;
    e_to = e_to | (delay - 1 >= T);
    e_read = 0; e_write = 0; e_stall = 0;
    e_ldv = ld & !flushed;
    e_ld = exp_load(f3, rd, off);
    if (lit_en && ld && !flushed) begin
      #3;
      chk("lit_ld_data", ld_data_o, l_ld);
    end
    tick();
    quiet();
  endtask

  initial begin
    rst = 1; dmem.rdata = 0; in_funct3 = 0; in_addr = 0; in_wdata = 0;
    quiet(); e_to = 0; e_addr = 0; e_mask = 0; e_wdata = 0; e_ld = 0;
    #2 rst = 0;
    #10;
    chk("rst_ld_data", ld_data_o, 32'h0);
    chk("rst_address", dmem.address, 32'h0);
    chkb("rst_read", dmem.read, 1'b0);
    chkb("rst_timeout", timeout_o, 1'b0);
    tick();
    rst = 1; chk_en = 1;
    idle(2);

    n_stall = 0; n_read = 0;
    do_op(1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 3, 0,
          1, 32'h100, 4'h0, 0, 32'hDEADBEEF);
    chk("lw_stall_cycles", n_stall, 4);
    chk("lw_read_cycles", n_read, 3);
    idle(1);

    do_op(1, 0, 3'd0, 32'h103, 0, 32'h80FF_0000, 1, 0,
          1, 32'h100, 4'h0, 0, 32'hFFFF_FF80);
    do_op(1, 0, 3'd4, 32'h103, 0, 32'h80FF_0000, 2, 0,
          1, 32'h100, 4'h0, 0, 32'h0000_0080);
    do_op(1, 0, 3'd5, 32'h102, 0, 32'h80FF_0000, 1, 0,
          1, 32'h100, 4'h0, 0, 32'h0000_80FF);
    do_op(1, 0, 3'd1, 32'h102, 0, 32'h80FF_0000, 1, 0,
          1, 32'h100, 4'h0, 0, 32'hFFFF_80FF);
    do_op(1, 0, 3'd0, 32'h201, 0, 32'h0000_7F00, 1, 0,
          1, 32'h200, 4'h0, 0, 32'h0000_007F);
    idle(1);

    do_op(0, 1, 3'd0, 32'h202, 32'h1234_56AB, 0, 2, 0,
          1, 32'h200, 4'b0100, 32'hABAB_ABAB, 0);
    do_op(0, 1, 3'd1, 32'h202, 32'h1234_56AB, 0, 1, 0,
          1, 32'h200, 4'b1100, 32'h56AB_56AB, 0);
    do_op(0, 1, 3'd2, 32'h204, 32'hCAFE_F00D, 0, 1, 0,
          1, 32'h204, 4'b1111, 32'hCAFE_F00D, 0);
    do_op(0, 1, 3'd7, 32'h20C, 32'h1122_3344, 0, 1, 0,
          1, 32'h20C, 4'b1111, 32'h1122_3344, 0);
    idle(1);

    do_op(1, 0, 3'd2, 32'h101, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    do_op(0, 1, 3'd1, 32'h203, 32'h5555, 0, 1, 0, 0, 0, 0, 0, 0);
    do_op(1, 0, 3'd1, 32'h101, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    do_op(1, 0, 3'd7, 32'h10A, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);

    do_op(1, 0, 3'd3, 32'h108, 0, 32'h89AB_CDEF, 2, 0,
          1, 32'h108, 4'h0, 0, 32'h89AB_CDEF);

    do_op(1, 0, 3'd2, 32'h300, 0, 32'h7777_7777, 3, 1,
          0, 0, 0, 0, 0);
    idle(1);
    do_op(0, 1, 3'd2, 32'h304, 32'h0102_0304, 0, 2, 2,
          0, 0, 0, 0, 0);
    idle(1);

    in_valid = 1; in_load = 1; in_funct3 = 3'd2;
    in_addr = 32'h100; flush = 1;
    e_stall = 0; e_mis = 0;
    tick();
    idle(1);
    in_valid = 1; in_load = 0; in_store = 0;
    tick();
    idle(1);

    in_valid = 1; in_load = 1; in_store = 0; in_funct3 = 3'd2;
    in_addr = 32'h400; e_stall = 1;
    tick();
    e_read = 1; e_addr = 32'h400; e_mask = 0;
    #1;
    rst = 0;
    quiet();
    #1;
    chkb("rst_async_read", dmem.read, 1'b0);
    chk("rst_async_ld_data", ld_data_o, 32'h0);
    tick();
    rst = 1;
    dmem.resp = 1; dmem.rdata = 32'hFFFF_FFFF;
    tick();
    quiet();
    tick();
    chk("stale_ld_data", ld_data_o, 32'h0);
    idle(1);

    do_op(1, 0, 3'd2, 32'h500, 0, 32'h0F0F_0F0F, 7, 0,
          1, 32'h500, 4'h0, 0, 32'h0F0F_0F0F);
    idle(2);
    chkb("timeout_sticky", timeout_o, 1'b1);
    do_op(1, 0, 3'd0, 32'h501, 0, 32'h0000_AA00, 1, 0,
          1, 32'h500, 4'h0, 0, 32'hFFFF_FFAA);
    rst = 0; e_to = 0;
    #1;
    chkb("timeout_cleared", timeout_o, 1'b0);
    tick();
    rst = 1;
    idle(2);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
